// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared sprite types and ball constants used by the renderer,
//               the collision logic and the ball motion engine.
// Revision    : 1.1 - adds the motion FSM state type and serve velocities
// ============================================================================
package sprite_pkg;

    // Screen coordinate widths (640x480 playfield fits in 10 bits each)
    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 10;

    // Ball geometry and serve velocities
    localparam int BALL_SIZE    = 10;
    localparam int BALL_INIT_VX = 3;
    localparam int BALL_INIT_VY = 1;

    // Bounding box published to the renderer and collision logic
    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    // Ball motion sequencing
    typedef enum logic [1:0] {
        MS_IDLE  = 2'b00,
        MS_SERVE = 2'b01,
        MS_MOVE  = 2'b10,
        MS_OUT   = 2'b11
    } sprite_motion_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_axis_step.sv
`default_nettype none
// ============================================================================
// Module      : sprite_axis_step
// Description : One-axis position step for the ball. Adds a signed velocity to
//               an unsigned position in a two-bit-wider signed domain so that
//               moves below zero are seen as underflow rather than wrapping,
//               and reports whether the sprite would leave [LIM_MIN, LIM_MAX].
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_axis_step #(
    parameter int POS_W   = 10,
    parameter int SPEED_W = 5,
    parameter int LIM_MIN = 10,
    parameter int LIM_MAX = 630,
    parameter int SIZE    = 10
) (
    input  logic [POS_W-1:0]   pos,
    input  logic [SPEED_W-1:0] vel,
    output logic [POS_W-1:0]   next_pos,
    output logic               under,
    output logic               over,
    output logic [POS_W-1:0]   clamp_pos
);

    localparam int c_SW = POS_W + 2;

    localparam logic signed [c_SW-1:0] c_MIN  = c_SW'(LIM_MIN);
    localparam logic signed [c_SW-1:0] c_MAX  = c_SW'(LIM_MAX);
    localparam logic signed [c_SW-1:0] c_SIZE = c_SW'(SIZE);
    localparam logic [POS_W-1:0]       c_LO   = POS_W'(LIM_MIN);
    localparam logic [POS_W-1:0]       c_HI   = POS_W'(LIM_MAX - SIZE);

    logic signed [c_SW-1:0] w_pos_ext;
    logic signed [c_SW-1:0] w_vel_ext;
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_SW-1:0] w_far;

    assign w_pos_ext = $signed({2'b00, pos});
    assign w_vel_ext = c_SW'($signed(vel));
    assign w_sum     = w_pos_ext + w_vel_ext;
    assign w_far     = w_sum + c_SIZE;

    assign under     = (w_sum < c_MIN);
    assign over      = (w_far > c_MAX);
    assign next_pos  = w_sum[POS_W-1:0];
    // Under and over are exclusive for any sane playfield; under picks the low edge
    assign clamp_pos = under ? c_LO : c_HI;

endmodule
`default_nettype wire

// File: rtl/sprite_motion.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion
// Description : Frame-synchronous motion engine for the ball sprite: serve
//               sequencing, wall bounces, paddle deflection and exit scoring.
//               Optional macro SPRITE_SUBPIXEL_EN keeps FRAC_W fraction bits
//               on the position; velocities are then in subpixel units.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int SIDE_W       = BALL_SIZE,
    parameter int SIDE_H       = BALL_SIZE,
    parameter int X_MIN        = 10,
    parameter int X_MAX        = 630,
    parameter int Y_MIN        = 10,
    parameter int Y_MAX        = 470,
    parameter int SPEED_W      = 5,
    parameter int INIT_VX      = BALL_INIT_VX,
    parameter int INIT_VY      = BALL_INIT_VY,
    parameter int SERVE_FRAMES = 60,
    parameter int FRAC_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic                        serve,
    input  logic                        serve_dir,
    input  logic                        deflect,
    input  logic [SPEED_W-1:0]          deflect_vy,
    output logic [$bits(sprite_t)-1:0]  sprite,
    output logic [SPEED_W-1:0]          vel_x,
    output logic [SPEED_W-1:0]          vel_y,
    output logic [1:0]                  state,
    output logic                        score_left,
    output logic                        score_right
);

`ifdef SPRITE_SUBPIXEL_EN
    localparam int c_FRAC = FRAC_W;
`else
    // Whole-pixel positions: FRAC_W has no effect in this build
    localparam int c_FRAC = 0 * FRAC_W;
`endif

    localparam int c_XW    = X_POS_W + c_FRAC;
    localparam int c_YW    = Y_POS_W + c_FRAC;
    localparam int c_CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [1:0] c_ST_IDLE  = MS_IDLE;
    localparam logic [1:0] c_ST_SERVE = MS_SERVE;
    localparam logic [1:0] c_ST_MOVE  = MS_MOVE;
    localparam logic [1:0] c_ST_OUT   = MS_OUT;

    localparam int c_XC_PIX = (X_MIN + X_MAX - SIDE_W) / 2;
    localparam int c_YC_PIX = (Y_MIN + Y_MAX - SIDE_H) / 2;

    localparam logic [c_XW-1:0]           c_X_CENTRE = c_XW'(c_XC_PIX << c_FRAC);
    localparam logic [c_YW-1:0]           c_Y_CENTRE = c_YW'(c_YC_PIX << c_FRAC);
    localparam logic signed [SPEED_W-1:0] c_VX       = SPEED_W'(INIT_VX);
    localparam logic signed [SPEED_W-1:0] c_VY       = SPEED_W'(INIT_VY);
    localparam logic [c_CNT_W-1:0]        c_CNT_LAST = c_CNT_W'(SERVE_FRAMES - 1);

    // Registered state
    logic [1:0]                  r_state;
    logic [c_XW-1:0]             r_x;
    logic [c_YW-1:0]             r_y;
    logic signed [SPEED_W-1:0]   r_vx;
    logic signed [SPEED_W-1:0]   r_vy;
    logic [c_CNT_W-1:0]          r_cnt;
    logic                        r_dir;
    logic                        r_pend;
    logic signed [SPEED_W-1:0]   r_dvy;
    logic                        r_score_left;
    logic                        r_score_right;
    sprite_t                     r_sprite;

    // Next-state values
    logic [1:0]                  w_state_nxt;
    logic [c_XW-1:0]             w_x_nxt;
    logic [c_YW-1:0]             w_y_nxt;
    logic signed [SPEED_W-1:0]   w_vx_nxt;
    logic signed [SPEED_W-1:0]   w_vy_nxt;
    logic [c_CNT_W-1:0]          w_cnt_nxt;
    logic                        w_dir_nxt;
    logic                        w_pend_nxt;
    logic signed [SPEED_W-1:0]   w_dvy_nxt;
    logic                        w_score_left_nxt;
    logic                        w_score_right_nxt;
    sprite_t                     w_sprite_nxt;

    // Velocities that apply to this tick's step (a deflect reverses first)
    logic                        w_pend_now;
    logic signed [SPEED_W-1:0]   w_dvy_now;
    logic signed [SPEED_W-1:0]   w_vx_eff;
    logic signed [SPEED_W-1:0]   w_vy_eff;

    // Axis step results
    logic [c_XW-1:0]             w_x_step;
    logic [c_XW-1:0]             w_x_clamp;
    logic                        w_x_under;
    logic                        w_x_over;
    logic [c_YW-1:0]             w_y_step;
    logic [c_YW-1:0]             w_y_clamp;
    logic                        w_y_under;
    logic                        w_y_over;

    assign w_pend_now = r_pend | deflect;
    assign w_dvy_now  = deflect ? $signed(deflect_vy) : r_dvy;
    assign w_vx_eff   = w_pend_now ? -r_vx : r_vx;
    assign w_vy_eff   = w_pend_now ? w_dvy_now : r_vy;

    sprite_axis_step #(
        .POS_W   (c_XW),
        .SPEED_W (SPEED_W),
        .LIM_MIN (X_MIN << c_FRAC),
        .LIM_MAX (X_MAX << c_FRAC),
        .SIZE    (SIDE_W << c_FRAC)
    ) u_x_step (
        .pos       (r_x),
        .vel       (w_vx_eff),
        .next_pos  (w_x_step),
        .under     (w_x_under),
        .over      (w_x_over),
        .clamp_pos (w_x_clamp)
    );

    sprite_axis_step #(
        .POS_W   (c_YW),
        .SPEED_W (SPEED_W),
        .LIM_MIN (Y_MIN << c_FRAC),
        .LIM_MAX (Y_MAX << c_FRAC),
        .SIZE    (SIDE_H << c_FRAC)
    ) u_y_step (
        .pos       (r_y),
        .vel       (w_vy_eff),
        .next_pos  (w_y_step),
        .under     (w_y_under),
        .over      (w_y_over),
        .clamp_pos (w_y_clamp)
    );

    // FSM, serve counter, deflect capture and per-frame position update
    always_comb begin
        w_state_nxt       = r_state;
        w_x_nxt           = r_x;
        w_y_nxt           = r_y;
        w_vx_nxt          = r_vx;
        w_vy_nxt          = r_vy;
        w_cnt_nxt         = r_cnt;
        w_dir_nxt         = r_dir;
        w_pend_nxt        = r_pend;
        w_dvy_nxt         = r_dvy;
        w_score_left_nxt  = 1'b0;
        w_score_right_nxt = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (serve) begin
                    w_dir_nxt   = serve_dir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_SERVE;
                end
            end

            c_ST_SERVE: begin
                if (frame_tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_vx_nxt    = r_dir ? c_VX : -c_VX;
                        w_vy_nxt    = c_VY;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_MOVE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            c_ST_MOVE: begin
                if (deflect) begin
                    w_pend_nxt = 1'b1;
                    w_dvy_nxt  = $signed(deflect_vy);
                end
                if (frame_tick) begin
                    w_pend_nxt = 1'b0;
                    w_vx_nxt   = w_vx_eff;
                    if (w_y_under || w_y_over) begin
                        w_y_nxt  = w_y_clamp;
                        w_vy_nxt = -w_vy_eff;
                    end else begin
                        w_y_nxt  = w_y_step;
                        w_vy_nxt = w_vy_eff;
                    end
                    if (w_x_under) begin
                        w_score_right_nxt = 1'b1;
                        w_state_nxt       = c_ST_OUT;
                    end else if (w_x_over) begin
                        w_score_left_nxt  = 1'b1;
                        w_state_nxt       = c_ST_OUT;
                    end else begin
                        w_x_nxt = w_x_step;
                    end
                end
            end

            default: begin
                // OUT: recentre and stop on the way back to IDLE
                w_state_nxt = c_ST_IDLE;
                w_x_nxt     = c_X_CENTRE;
                w_y_nxt     = c_Y_CENTRE;
                w_vx_nxt    = '0;
                w_vy_nxt    = '0;
                w_pend_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase

        w_sprite_nxt.x_pos  = w_x_nxt[c_XW-1 -: X_POS_W];
        w_sprite_nxt.y_pos  = w_y_nxt[c_YW-1 -: Y_POS_W];
        w_sprite_nxt.right  = w_x_nxt[c_XW-1 -: X_POS_W] + X_POS_W'(SIDE_W - 1);
        w_sprite_nxt.bottom = w_y_nxt[c_YW-1 -: Y_POS_W] + Y_POS_W'(SIDE_H - 1);
    end

    // State and output registers; bounding box updates together with position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_x             <= c_X_CENTRE;
            r_y             <= c_Y_CENTRE;
            r_vx            <= '0;
            r_vy            <= '0;
            r_cnt           <= '0;
            r_dir           <= 1'b0;
            r_pend          <= 1'b0;
            r_dvy           <= '0;
            r_score_left    <= 1'b0;
            r_score_right   <= 1'b0;
            r_sprite.x_pos  <= X_POS_W'(c_XC_PIX);
            r_sprite.y_pos  <= Y_POS_W'(c_YC_PIX);
            r_sprite.right  <= X_POS_W'(c_XC_PIX + SIDE_W - 1);
            r_sprite.bottom <= Y_POS_W'(c_YC_PIX + SIDE_H - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_vx          <= w_vx_nxt;
            r_vy          <= w_vy_nxt;
            r_cnt         <= w_cnt_nxt;
            r_dir         <= w_dir_nxt;
            r_pend        <= w_pend_nxt;
            r_dvy         <= w_dvy_nxt;
            r_score_left  <= w_score_left_nxt;
            r_score_right <= w_score_right_nxt;
            r_sprite      <= w_sprite_nxt;
        end
    end

    assign sprite      = r_sprite;
    assign vel_x       = r_vx;
    assign vel_y       = r_vy;
    assign state       = r_state;
    assign score_left  = r_score_left;
    assign score_right = r_score_right;

endmodule
`default_nettype wire

// File: doc/sprite_motion.md
# sprite_motion

Parametrised, frame-synchronous motion engine for one rectangular sprite (the ball), generalising the fixed ball constants of the shared sprite package. It owns:

- position and signed velocity;
- serve sequencing;
- top/bottom wall bounces;
- paddle deflection;
- left/right exit detection.

It publishes the bounding box as a `sprite_t` for the renderer and collision logic. It sits between the VGA timing generator (`frame_tick`) and the paddle-collision detector (`deflect`).

## Interface

Parameters:

- `SIDE_W`, 10: sprite width in pixels.
- `SIDE_H`, 10: sprite height in pixels.
- `X_MIN`, 10 / `X_MAX`, 630: horizontal playfield limits. The sprite occupies `x_pos`..`x_pos+SIDE_W-1`.
- `Y_MIN`, 10 / `Y_MAX`, 470: vertical playfield limits.
- `SPEED_W`, 5: signed velocity width.
- `INIT_VX`, 3: serve horizontal speed magnitude.
- `INIT_VY`, 1: serve vertical velocity, signed.
- `SERVE_FRAMES`, 60: frames between serve request and launch.
- `FRAC_W`, 4: subpixel fraction bits. Used only with `SPRITE_SUBPIXEL_EN`.

Ports:

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame, at start of vertical blanking.
- `serve` in 1: launch request pulse. Accepted only in IDLE.
- `serve_dir` in 1: 0 = toward left, 1 = toward right. Sampled with `serve`.
- `deflect` in 1: paddle hit pulse from the collision detector.
- `deflect_vy` in `SPEED_W`: signed vertical velocity to apply on deflect. Sampled with `deflect`.
- `sprite` out `$bits(sprite_t)`: registered `x_pos`, `y_pos`, `right`, `bottom`.
- `vel_x`, `vel_y` out `SPEED_W`: current signed velocities.
- `state` out 2: current FSM state.
- `score_left` out 1: one-cycle pulse; sprite exited right, left player scores.
- `score_right` out 1: one-cycle pulse; sprite exited left, right player scores.

## Operation

FSM states:

- **IDLE (00)**: sprite held at centre, `X_C=(X_MIN+X_MAX-SIDE_W)/2` and `Y_C=(Y_MIN+Y_MAX-SIDE_H)/2`; velocities 0. `serve` latches `serve_dir`, clears the frame counter and moves to SERVE.
- **SERVE (01)**: counts `frame_tick`. On the `SERVE_FRAMES`-th tick it loads `vel_x=±INIT_VX` (sign from `serve_dir`) and `vel_y=INIT_VY`, then moves to MOVE. Position does not change on that tick.
- **MOVE (10)**: `deflect` sets a sticky pending flag and captures `deflect_vy`; a later `deflect` overwrites the captured value. On each `frame_tick`:
  - If pending: `vel_x←-vel_x`, `vel_y←captured`, flag cleared. The new velocities are used for this tick's step.
  - Y step: if `y+vy<Y_MIN`, clamp `y=Y_MIN` and negate `vy`. If `y+vy+SIDE_H>Y_MAX`, clamp `y=Y_MAX-SIDE_H` and negate `vy`.
  - X step: if `x+vx<X_MIN`, pulse `score_right` and go to OUT. If `x+vx+SIDE_W>X_MAX`, pulse `score_left` and go to OUT. Otherwise `x←x+vx`.
  - A deflect pending on the same tick as an exit wins: the velocity is reversed before the X check.
- **OUT (11)**: one cycle, then IDLE. The position recentres on entry to IDLE.

Arithmetic and boundary rules:

- All sums are computed sign-extended to `X_POS_W+2` / `Y_POS_W+2` bits, so underflow below 0 is detected, not wrapped.
- `right=x_pos+SIDE_W-1` and `bottom=y_pos+SIDE_H-1`, registered together with the position.
- `serve` outside IDLE is ignored. `deflect` outside MOVE is ignored and not queued.
- `rst` at any time forces IDLE and centre, zero velocities, no pulses, pending cleared, counter 0.

## Timing

- Reset values:
  - `sprite.x_pos=X_C`, `sprite.y_pos=Y_C`, `right=X_C+SIDE_W-1`, `bottom=Y_C+SIDE_H-1`. Defaults: 315, 235, 324, 244.
  - `vel_x=0`, `vel_y=0`, `state=00`, both score pulses 0.
- Latency: all outputs update in the cycle after the `frame_tick` edge. One update per tick, no pipelining across frames.
- `serve` and `frame_tick` in the same IDLE cycle: the serve is accepted; that tick is not counted.
- `deflect` coincident with `frame_tick`: applied on that tick.

## Configuration

`SPRITE_SUBPIXEL_EN` enables subpixel positioning.

- **Defined**: position is held with `FRAC_W` extra fraction bits. Velocity is in units of 1/2^`FRAC_W` pixel per frame. Outputs are the integer part. Clamps set the fraction to 0. `INIT_VX` and `INIT_VY` are in the same subpixel units.
- **Undefined**: velocity is in whole pixels per frame, no fraction registers exist, and `FRAC_W` is ignored.

## Structure

- `sprite_pkg` gains:
  - `sprite_motion_state_t`: 2-bit enum with IDLE, SERVE, MOVE and OUT.
  - `BALL_INIT_VX` and `BALL_INIT_VY`.
- `sprite_t` is reused unchanged.
- Sub-module `sprite_axis_step`: one instance per axis. It is parametrised on limit, size and width, takes position and velocity, and returns the next position, an under/over flag and the clamped position. Top level holds the FSM, counter, pending flag and registers.

## Test plan

All cases use defaults with `SPRITE_SUBPIXEL_EN` undefined.

- **Reset**: assert `rst` mid-MOVE → next cycle `x=315`, `y=235`, `right=324`, `bottom=244`, `vel=0`, `state=00`.
- **Serve**: `serve`, `serve_dir=1` → state 01; 60 ticks later `vel_x=+3`, `vel_y=+1`. After the next tick `x=318`, `y=236`.
- **Wall bounce**: `y=462`, `vy=+1`, tick → `y=460`, `vy=-1`. `y=10`, `vy=-1`, tick → `y=10`, `vy=+1`.
- **Exit**: `x=12`, `vx=-3`, tick → `score_right` pulses one cycle, state 11 then 00, `x=315`.
- **Deflect**: `deflect` with `deflect_vy=-2` mid-frame, `x=100`, `vx=-3` → next tick `vx=+3`, `vy=-2`, `x=103`.
- **Deflect vs exit**: `deflect` plus `x=12`, `vx=-3` on the same tick → no score, `x=15`, `vx=+3`.
